seg_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver for the FPGA top level, generalising the fixed 6-digit, 8-bit segment output into an N-digit hex display. It supports double-buffered loads, per-digit blanking and decimal points, leading-zero suppression, 16-level brightness PWM and anti-ghosting dead time. It takes a packed hex value from the system (e.g. RAM address or debug register) and drives `seg_data`/`seg_sel` pins directly.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex_decoder.sv | 20 ++
 rtl/seg_scan_driver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and the hex-to-seven-segment table for the
//               multiplexed display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Phase of the current digit slot
  typedef enum logic [1:0] {
    DEAD = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } seg_state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by nibble value
  localparam logic [6:0] c_hex7_table [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return c_hex7_table[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational nibble to seven-segment {g..a} decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern
  always_comb begin
    seg_o = hex7(nibble_i);
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed N-digit hex display driver with a double
//               buffered load path, blanking, decimal points, leading-zero
//               suppression, 16-level PWM brightness and dead time per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int DIGIT_CYCLES   = 4096,
  parameter int DEAD_CYCLES    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [3:0]              bright_i,
  input  logic                    lz_en_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] c_dig_last = DW'(NUM_DIGITS - 1);
  localparam int c_span = DIGIT_CYCLES - DEAD_CYCLES;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  seg_state_e    state_q, state_d;

  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d, act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [3:0]              sh_bright_q, sh_bright_d, act_bright_q, act_bright_d;
  logic                    sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
  logic                    pending_q, pending_d, frame_q, frame_d;
  logic [7:0]              seg_raw_q, seg_raw_d;
  logic [NUM_DIGITS-1:0]   sel_raw_q, sel_raw_d;

  logic                    w_transfer;
  int                      w_on_len;
  logic [NUM_DIGITS-1:0]   w_dark;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_nibble;
  logic                    w_dp_sel;
  logic                    w_dark_sel;
  logic [6:0]              w_hex;
  logic                    w_lit;

  // Shadow-to-active handoff happens only at the very start of a frame
  assign w_transfer = (dig_q == '0) && (cnt_q == '0);
  assign w_on_len   = (c_span * (int'(act_bright_q) + 1)) >> 4;

  // Slot counters and DEAD/ON/OFF phase for the upcoming cycle
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    dig_d   = dig_q;
    state_d = state_q;
    if (cnt_q == c_cnt_last) begin
      cnt_d = '0;
      dig_d = (dig_q == c_dig_last) ? '0 : dig_q + 1'b1;
    end
    if (int'(cnt_d) < DEAD_CYCLES) begin
      state_d = DEAD;
    end else if (int'(cnt_d) < DEAD_CYCLES + w_on_len) begin
      state_d = ON;
    end else begin
      state_d = OFF;
    end
  end

  // Counter and phase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      state_q <= DEAD;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
    end
  end

  // Dark mask: blanking plus suppression of an all-zero, dp-free upper run
  always_comb begin
    logic run;
    run    = 1'b1;
    w_dark = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run       = run & (act_value_q[4*k +: 4] == 4'h0) & ~act_dp_q[k];
      w_dark[k] = act_blank_q[k] | (act_lz_q & run & (k != 0));
    end
  end

  // Select the fields of the digit currently being scanned
  always_comb begin
    w_nibble   = '0;
    w_dp_sel   = 1'b0;
    w_dark_sel = 1'b0;
    w_onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q == DW'(k)) begin
        w_nibble    = act_value_q[4*k +: 4];
        w_dp_sel    = act_dp_q[k];
        w_dark_sel  = w_dark[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  seg_hex_decoder u_hex_decoder (
    .nibble_i (w_nibble),
    .seg_o    (w_hex)
  );

  // Active-high pin images; lit only in the ON phase of a non-dark digit
  always_comb begin
    w_lit     = (state_q == ON) && !w_dark_sel;
    seg_raw_d = w_lit ? {w_dp_sel, w_hex} : 8'h00;
    sel_raw_d = w_lit ? w_onehot : '0;
  end

  // Double buffer: loads go to shadow, transfer uses the pre-load shadow
  always_comb begin
    sh_value_d   = sh_value_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    sh_bright_d  = sh_bright_q;
    sh_lz_d      = sh_lz_q;
    act_value_d  = act_value_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_bright_d = act_bright_q;
    act_lz_d     = act_lz_q;
    pending_d    = pending_q;
    frame_d      = w_transfer;
    if (w_transfer && pending_q) begin
      act_value_d  = sh_value_q;
      act_dp_d     = sh_dp_q;
      act_blank_d  = sh_blank_q;
      act_bright_d = sh_bright_q;
      act_lz_d     = sh_lz_q;
      pending_d    = 1'b0;
    end
    if (load_i) begin
      sh_value_d  = value_i;
      sh_dp_d     = dp_i;
      sh_blank_d  = blank_i;
      sh_bright_d = bright_i;
      sh_lz_d     = lz_en_i;
      pending_d   = 1'b1;
    end
  end

  // Buffer, status and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_value_q   <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_bright_q  <= 4'hF;
      sh_lz_q      <= 1'b0;
      act_value_q  <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_bright_q <= 4'hF;
      act_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
      frame_q      <= 1'b0;
      seg_raw_q    <= '0;
      sel_raw_q    <= '0;
    end else begin
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_bright_q  <= sh_bright_d;
      sh_lz_q      <= sh_lz_d;
      act_value_q  <= act_value_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_bright_q <= act_bright_d;
      act_lz_q     <= act_lz_d;
      pending_q    <= pending_d;
      frame_q      <= frame_d;
      seg_raw_q    <= seg_raw_d;
      sel_raw_q    <= sel_raw_d;
    end
  end

  // Pin polarity is applied after the output registers
  assign seg_o     = seg_raw_q ^ {8{SEG_ACTIVE_LOW}};
  assign sel_o     = sel_raw_q ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
  assign frame_o   = frame_q;
  assign pending_o = pending_q;

endmodule
`default_nettype wire
